// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned FWD_W = 2;
    localparam int unsigned PC_W  = 2;
    localparam int unsigned ERR_W = 3;

    // Forwarding select codes
    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_EX  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b11;

    // Next-PC source codes
    localparam logic [PC_W-1:0] PCS_NRM = 2'b00;
    localparam logic [PC_W-1:0] PCS_JPA = 2'b01;
    localparam logic [PC_W-1:0] PCS_BRA = 2'b10;

    // Error cause bit positions
    localparam int unsigned ERR_SHIFT   = 0;
    localparam int unsigned ERR_COP     = 1;
    localparam int unsigned ERR_TIMEOUT = 2;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side signal bundle of the hazard controller.
interface hazard_ctrl_unit_if #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned CNT_W   = 16
) ();

    logic                        enable_cpu;
    logic                        shift_error;
    logic [NUM_SRC*ADDR_W-1:0]   src_addr;
    logic [NUM_SRC-1:0]          src_read;
    logic                        ex_reg_write;
    logic                        ex_mem_rd;
    logic [ADDR_W-1:0]           ex_wr_addr;
    logic                        ex_branch_taken;
    logic                        mem_reg_write;
    logic [ADDR_W-1:0]           mem_wr_addr;
    logic                        wb_reg_write;
    logic [ADDR_W-1:0]           wb_wr_addr;
    logic                        id_jump_flag;
    logic                        cop_working;
    logic                        cop_result_valid;
    logic                        cop_error;
    logic                        err_clear;

    logic [NUM_SRC*2-1:0]        src_forward;
    logic [1:0]                  pc_src;
    logic                        if_id_flush;
    logic                        id_ex_flush;
    logic                        if_id_stall;
    logic                        id_ex_cen;
    logic                        ex_mem_cen;
    logic                        mem_wb_cen;
    logic                        cpu_error;
    logic [hazard_pkg::ERR_W-1:0] error_cause;
    logic [CNT_W-1:0]            stall_cnt;
    logic [CNT_W-1:0]            flush_cnt;

    // Pipeline side: drives status, receives control
    modport master (
        output enable_cpu, shift_error, src_addr, src_read,
               ex_reg_write, ex_mem_rd, ex_wr_addr, ex_branch_taken,
               mem_reg_write, mem_wr_addr, wb_reg_write, wb_wr_addr,
               id_jump_flag, cop_working, cop_result_valid, cop_error, err_clear,
        input  src_forward, pc_src, if_id_flush, id_ex_flush, if_id_stall,
               id_ex_cen, ex_mem_cen, mem_wb_cen, cpu_error, error_cause,
               stall_cnt, flush_cnt
    );

    // Hazard controller side
    modport slave (
        input  enable_cpu, shift_error, src_addr, src_read,
               ex_reg_write, ex_mem_rd, ex_wr_addr, ex_branch_taken,
               mem_reg_write, mem_wr_addr, wb_reg_write, wb_wr_addr,
               id_jump_flag, cop_working, cop_result_valid, cop_error, err_clear,
        output src_forward, pc_src, if_id_flush, id_ex_flush, if_id_stall,
               id_ex_cen, ex_mem_cen, mem_wb_cen, cpu_error, error_cause,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_src_match.sv
// One source port: EX/MEM/WB destination compares, forward select, load-use flag.
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] src_addr,
    input  logic              src_read,
    input  logic              ex_reg_write,
    input  logic              ex_mem_rd,
    input  logic [ADDR_W-1:0] ex_wr_addr,
    input  logic              mem_reg_write,
    input  logic [ADDR_W-1:0] mem_wr_addr,
    input  logic              wb_reg_write,
    input  logic [ADDR_W-1:0] wb_wr_addr,
    output logic [FWD_W-1:0]  fwd_sel_c,
    output logic              load_use_c
);

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    // Stage hits; r0 is never a forwarding source
    always_comb begin
        ex_hit  = src_read && ex_reg_write  && (ex_wr_addr  != '0) && (ex_wr_addr  == src_addr);
        mem_hit = src_read && mem_reg_write && (mem_wr_addr != '0) && (mem_wr_addr == src_addr);
        wb_hit  = src_read && wb_reg_write  && (wb_wr_addr  != '0) && (wb_wr_addr  == src_addr);
    end

    // Youngest producer wins; a pending load blocks forwarding entirely
    always_comb begin
        fwd_sel_c  = FWD_RF;
        load_use_c = ex_hit && ex_mem_rd;
        if (load_use_c) begin
            fwd_sel_c = FWD_RF;
        end else if (ex_hit) begin
            fwd_sel_c = FWD_EX;
        end else if (mem_hit) begin
            fwd_sel_c = FWD_MEM;
        end else if (wb_hit) begin
            fwd_sel_c = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: forwarding, stalls/flushes, error register, counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned NUM_SRC     = 2,
    parameter int unsigned COP_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_ctrl_unit_if.slave  bus
);

    localparam int unsigned WD_W = $clog2(COP_TIMEOUT + 1);

    logic [NUM_SRC*FWD_W-1:0] fwd_all;
    logic [NUM_SRC-1:0]       lu_vec;

    logic             load_use;
    logic             lu_eff;
    logic             cop_wait;
    logic             jump_ok;
    logic             in_error;
    logic             run_ok;

    logic [WD_W-1:0]  wd_q, wd_d;
    logic             wd_hit;
    logic [ERR_W-1:0] cause_q, cause_d;
    logic [ERR_W-1:0] err_set;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    // Per-port compare slices
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hazard_src_match #(.ADDR_W(ADDR_W)) u_match (
            .src_addr      (bus.src_addr[i*ADDR_W +: ADDR_W]),
            .src_read      (bus.src_read[i]),
            .ex_reg_write  (bus.ex_reg_write),
            .ex_mem_rd     (bus.ex_mem_rd),
            .ex_wr_addr    (bus.ex_wr_addr),
            .mem_reg_write (bus.mem_reg_write),
            .mem_wr_addr   (bus.mem_wr_addr),
            .wb_reg_write  (bus.wb_reg_write),
            .wb_wr_addr    (bus.wb_wr_addr),
            .fwd_sel_c     (fwd_all[i*FWD_W +: FWD_W]),
            .load_use_c    (lu_vec[i])
        );
    end

    // Hazard conditions shared by the control outputs
    always_comb begin
        load_use = |lu_vec;
        lu_eff   = load_use & ~bus.ex_branch_taken;
        cop_wait = bus.cop_working & ~bus.cop_result_valid;
        jump_ok  = bus.id_jump_flag & ~cop_wait;
        in_error = |cause_q;
        run_ok   = bus.enable_cpu & ~in_error & ~cop_wait;
    end

    // Pipeline control; reset forces flush/stall and a normal PC
    always_comb begin
        bus.src_forward = fwd_all;
        bus.if_id_flush = ~rst_n | bus.ex_branch_taken | jump_ok;
        bus.id_ex_flush = ~rst_n | bus.ex_branch_taken | jump_ok | lu_eff;
        bus.if_id_stall = ~rst_n | lu_eff | ~bus.enable_cpu | in_error | cop_wait;
        bus.id_ex_cen   = rst_n & run_ok;
        bus.ex_mem_cen  = rst_n & run_ok;
        bus.mem_wb_cen  = rst_n & run_ok;
        bus.pc_src      = PCS_NRM;
        if (rst_n) begin
            if (bus.ex_branch_taken) begin
                bus.pc_src = PCS_BRA;
            end else if (jump_ok) begin
                bus.pc_src = PCS_JPA;
            end
        end
        bus.cpu_error   = in_error;
        bus.error_cause = cause_q;
        bus.stall_cnt   = stall_q;
        bus.flush_cnt   = flush_q;
    end

    // Coprocessor watchdog: counts consecutive wait cycles, saturating
    always_comb begin
        wd_d   = '0;
        wd_hit = 1'b0;
        if (cop_wait) begin
            wd_hit = (wd_q == WD_W'(COP_TIMEOUT - 1));
            wd_d   = (wd_q == WD_W'(COP_TIMEOUT)) ? wd_q : wd_q + WD_W'(1);
        end
    end

    // Sticky causes; a new set beats a same-cycle clear
    always_comb begin
        err_set              = '0;
        err_set[ERR_SHIFT]   = bus.shift_error;
        err_set[ERR_COP]     = bus.cop_error & bus.cop_result_valid;
        err_set[ERR_TIMEOUT] = wd_hit;
        cause_d              = err_set | (cause_q & {ERR_W{~bus.err_clear}});
    end

    // Saturating performance counters
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if ((lu_eff | cop_wait) && bus.enable_cpu && !in_error && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if ((bus.ex_branch_taken | jump_ok) && (flush_q != '1)) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q    <= '0;
            cause_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            wd_q    <= wd_d;
            cause_q <= cause_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Randomized and directed bench for hazard_ctrl_unit against a behavioural model.
module tb_hazard_ctrl_unit;
    import hazard_pkg::*;

    localparam int unsigned ADDR_W      = 5;
    localparam int unsigned NUM_SRC     = 2;
    localparam int unsigned COP_TIMEOUT = 4;
    localparam int unsigned CNT_W       = 4;
    localparam int          CNT_MAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;

    hazard_ctrl_unit_if #(.ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) bus ();

    hazard_ctrl_unit #(
        .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .COP_TIMEOUT(COP_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: consecutive wait run length, cause bits, event counts
    int         m_run;
    logic [2:0] m_cause;
    int         m_stall;
    int         m_flush;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_run = 0; m_cause = 3'b000; m_stall = 0; m_flush = 0;
    endtask

    task automatic idle();
        bus.enable_cpu = 1'b1; bus.shift_error = 1'b0;
        bus.src_addr = '0; bus.src_read = '0;
        bus.ex_reg_write = 1'b0; bus.ex_mem_rd = 1'b0; bus.ex_wr_addr = '0;
        bus.ex_branch_taken = 1'b0;
        bus.mem_reg_write = 1'b0; bus.mem_wr_addr = '0;
        bus.wb_reg_write = 1'b0; bus.wb_wr_addr = '0;
        bus.id_jump_flag = 1'b0;
        bus.cop_working = 1'b0; bus.cop_result_valid = 1'b0; bus.cop_error = 1'b0;
        bus.err_clear = 1'b0;
    endtask

    task automatic drive_random();
        logic [NUM_SRC*ADDR_W-1:0] a;
        a = '0;
        for (int i = 0; i < NUM_SRC; i++) a[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 3));
        bus.src_addr         = a;
        bus.src_read         = NUM_SRC'($urandom);
        bus.enable_cpu       = ($urandom_range(0, 9) != 0);
        bus.shift_error      = ($urandom_range(0, 29) == 0);
        bus.ex_reg_write     = 1'($urandom);
        bus.ex_mem_rd        = 1'($urandom);
        bus.ex_wr_addr       = ADDR_W'($urandom_range(0, 3));
        bus.ex_branch_taken  = ($urandom_range(0, 4) == 0);
        bus.mem_reg_write    = 1'($urandom);
        bus.mem_wr_addr      = ADDR_W'($urandom_range(0, 3));
        bus.wb_reg_write     = 1'($urandom);
        bus.wb_wr_addr       = ADDR_W'($urandom_range(0, 3));
        bus.id_jump_flag     = ($urandom_range(0, 4) == 0);
        bus.cop_working      = ($urandom_range(0, 2) == 0);
        bus.cop_result_valid = 1'($urandom);
        bus.cop_error        = ($urandom_range(0, 3) == 0);
        bus.err_clear        = ($urandom_range(0, 3) == 0);
    endtask

    // Compare every output with the rules, then advance the model past the coming edge
    task automatic model_check();
        logic [NUM_SRC*2-1:0] efwd;
        logic [ADDR_W-1:0]    a;
        logic lu, bt, cw, jok, err, lub, ex_h, mem_h, wb_h, en;
        logic [1:0] epc;
        logic [2:0] set;
        efwd = '0; lu = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            a     = bus.src_addr[i*ADDR_W +: ADDR_W];
            ex_h  = bus.src_read[i] && bus.ex_reg_write  && bus.ex_wr_addr  != 0 && bus.ex_wr_addr  == a;
            mem_h = bus.src_read[i] && bus.mem_reg_write && bus.mem_wr_addr != 0 && bus.mem_wr_addr == a;
            wb_h  = bus.src_read[i] && bus.wb_reg_write  && bus.wb_wr_addr  != 0 && bus.wb_wr_addr  == a;
            if (ex_h && bus.ex_mem_rd) begin lu = 1'b1; efwd[2*i +: 2] = 2'd0; end
            else if (ex_h)  efwd[2*i +: 2] = 2'd1;
            else if (mem_h) efwd[2*i +: 2] = 2'd2;
            else if (wb_h)  efwd[2*i +: 2] = 2'd3;
        end
        err = (m_cause != 3'b000);
        bt  = bus.ex_branch_taken;
        cw  = bus.cop_working && !bus.cop_result_valid;
        jok = bus.id_jump_flag && !cw;
        lub = lu && !bt;
        en  = bus.enable_cpu && !err && !cw;
        epc = bt ? 2'd2 : (jok ? 2'd1 : 2'd0);

        check("src_forward", 32'(bus.src_forward), 32'(efwd));
        check("pc_src",      32'(bus.pc_src), 32'(epc));
        check("if_id_flush", 32'(bus.if_id_flush), 32'(bt || jok));
        check("id_ex_flush", 32'(bus.id_ex_flush), 32'(bt || jok || lub));
        check("if_id_stall", 32'(bus.if_id_stall), 32'(lub || !bus.enable_cpu || err || cw));
        check("id_ex_cen",   32'(bus.id_ex_cen), 32'(en));
        check("ex_mem_cen",  32'(bus.ex_mem_cen), 32'(en));
        check("mem_wb_cen",  32'(bus.mem_wb_cen), 32'(en));
        check("cpu_error",   32'(bus.cpu_error), 32'(err));
        check("error_cause", 32'(bus.error_cause), 32'(m_cause));
        check("stall_cnt",   32'(bus.stall_cnt), 32'(m_stall));
        check("flush_cnt",   32'(bus.flush_cnt), 32'(m_flush));

        set[0] = bus.shift_error;
        set[1] = bus.cop_error && bus.cop_result_valid;
        set[2] = cw && (m_run == int'(COP_TIMEOUT) - 1);
        m_run  = cw ? m_run + 1 : 0;
        for (int b = 0; b < 3; b++) begin
            if (set[b]) m_cause[b] = 1'b1;
            else if (bus.err_clear) m_cause[b] = 1'b0;
        end
        if ((lub || cw) && bus.enable_cpu && !err && m_stall < CNT_MAX) m_stall++;
        if ((bt || jok) && m_flush < CNT_MAX) m_flush++;
    endtask

    task automatic begin_cycle();
        @(negedge clk);
        idle();
    endtask

    task automatic end_cycle();
        #1;
        model_check();
    endtask

    task automatic check_in_reset(input string tag);
        check({tag, "_if_id_flush"}, 32'(bus.if_id_flush), 32'd1);
        check({tag, "_id_ex_flush"}, 32'(bus.id_ex_flush), 32'd1);
        check({tag, "_if_id_stall"}, 32'(bus.if_id_stall), 32'd1);
        check({tag, "_cen"},         32'({bus.id_ex_cen, bus.ex_mem_cen, bus.mem_wb_cen}), 32'd0);
        check({tag, "_pc_src"},      32'(bus.pc_src), 32'd0);
        check({tag, "_cause"},       32'(bus.error_cause), 32'd0);
        check({tag, "_cpu_error"},   32'(bus.cpu_error), 32'd0);
        check({tag, "_stall_cnt"},   32'(bus.stall_cnt), 32'd0);
        check({tag, "_flush_cnt"},   32'(bus.flush_cnt), 32'd0);
    endtask

    task automatic set_load_use_r5();
        bus.ex_reg_write = 1'b1; bus.ex_mem_rd = 1'b1; bus.ex_wr_addr = 5'd5;
        bus.src_addr = {5'd5, 5'd0}; bus.src_read = 2'b10;
    endtask

    logic [NUM_SRC*2-1:0] f;

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        #12;
        check_in_reset("por");

        // Forwarding priority on port 0 reading r3
        @(negedge clk); rst_n = 1'b1;
        idle();
        bus.src_addr = {5'd0, 5'd3}; bus.src_read = 2'b01;
        bus.ex_reg_write = 1'b1; bus.ex_wr_addr = 5'd3;
        bus.mem_reg_write = 1'b1; bus.mem_wr_addr = 5'd3;
        bus.wb_reg_write = 1'b1; bus.wb_wr_addr = 5'd3;
        end_cycle(); f = bus.src_forward; check("prio_ex", 32'(f[1:0]), 32'(FWD_EX));
        @(negedge clk); bus.ex_reg_write = 1'b0;
        end_cycle(); f = bus.src_forward; check("prio_mem", 32'(f[1:0]), 32'(FWD_MEM));
        @(negedge clk); bus.mem_reg_write = 1'b0;
        end_cycle(); f = bus.src_forward; check("prio_wb", 32'(f[1:0]), 32'(FWD_WB));
        @(negedge clk);
        bus.src_addr = '0; bus.ex_reg_write = 1'b1; bus.mem_reg_write = 1'b1;
        bus.ex_wr_addr = '0; bus.mem_wr_addr = '0; bus.wb_wr_addr = '0;
        end_cycle(); f = bus.src_forward; check("prio_r0", 32'(f[1:0]), 32'(FWD_RF));

        // Load-use, then the same hazard under a taken branch
        begin_cycle(); set_load_use_r5();
        end_cycle();
        f = bus.src_forward;
        check("lu_stall", 32'(bus.if_id_stall), 32'd1);
        check("lu_flush", 32'(bus.id_ex_flush), 32'd1);
        check("lu_fwd1",  32'(f[3:2]), 32'(FWD_RF));
        begin_cycle(); set_load_use_r5(); bus.ex_branch_taken = 1'b1;
        end_cycle();
        check("lu_bt_stall", 32'(bus.if_id_stall), 32'd0);
        check("lu_bt_pc",    32'(bus.pc_src), 32'(PCS_BRA));

        // Jump held off by a coprocessor wait
        begin_cycle(); bus.id_jump_flag = 1'b1; bus.cop_working = 1'b1;
        end_cycle();
        check("jw_flush", 32'(bus.if_id_flush), 32'd0);
        check("jw_pc",    32'(bus.pc_src), 32'(PCS_NRM));
        check("jw_cen",   32'(bus.id_ex_cen), 32'd0);
        begin_cycle(); bus.id_jump_flag = 1'b1;
        end_cycle();
        check("j_pc",    32'(bus.pc_src), 32'(PCS_JPA));
        check("j_flush", 32'({bus.if_id_flush, bus.id_ex_flush}), 32'd3);

        // Watchdog timeout after COP_TIMEOUT wait cycles
        for (int k = 0; k < int'(COP_TIMEOUT); k++) begin
            begin_cycle(); bus.cop_working = 1'b1; end_cycle();
        end
        begin_cycle(); end_cycle();
        check("wd_cause", 32'(bus.error_cause), 32'b100);
        check("wd_err",   32'(bus.cpu_error), 32'd1);
        check("wd_cen",   32'(bus.mem_wb_cen), 32'd0);
        begin_cycle(); bus.err_clear = 1'b1; end_cycle();
        for (int k = 0; k < int'(COP_TIMEOUT) - 1; k++) begin
            begin_cycle(); bus.cop_working = 1'b1; end_cycle();
        end
        begin_cycle(); end_cycle();
        check("wd_short", 32'(bus.error_cause), 32'b000);

        // Error set/clear precedence
        begin_cycle(); bus.shift_error = 1'b1; end_cycle();
        begin_cycle();
        bus.err_clear = 1'b1; bus.cop_error = 1'b1; bus.cop_result_valid = 1'b1;
        end_cycle();
        check("ec_shift", 32'(bus.error_cause), 32'b001);
        begin_cycle(); bus.err_clear = 1'b1; end_cycle();
        check("ec_cop", 32'(bus.error_cause), 32'b010);
        begin_cycle(); end_cycle();
        check("ec_clear",  32'(bus.error_cause), 32'b000);
        check("ec_resume", 32'(bus.mem_wb_cen), 32'd1);

        // Stall counter saturation
        for (int k = 0; k < 20; k++) begin
            begin_cycle(); set_load_use_r5(); end_cycle();
        end
        begin_cycle(); end_cycle();
        check("stall_sat", 32'(bus.stall_cnt), 32'(CNT_MAX));

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            @(negedge clk); drive_random(); end_cycle();
        end

        // Build cause 101 with a wait in flight, then reset between edges
        begin_cycle(); bus.err_clear = 1'b1; end_cycle();
        begin_cycle(); bus.shift_error = 1'b1; bus.id_jump_flag = 1'b1; end_cycle();
        for (int k = 0; k < int'(COP_TIMEOUT); k++) begin
            begin_cycle(); bus.cop_working = 1'b1; end_cycle();
        end
        begin_cycle(); bus.cop_working = 1'b1; end_cycle();
        check("pre_rst_cause", 32'(bus.error_cause), 32'b101);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_in_reset("async");
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        idle(); bus.cop_working = 1'b1;
        end_cycle();
        for (int k = 0; k < int'(COP_TIMEOUT) - 2; k++) begin
            begin_cycle(); bus.cop_working = 1'b1; end_cycle();
        end
        begin_cycle(); end_cycle();
        check("wd_restart", 32'(bus.error_cause), 32'b000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised pipeline hazard controller for the five-stage core, successor to the fixed two-source controller. It sits beside the ID stage and provides three services:
- Forwarding selects for `NUM_SRC` register-read ports, from EX, MEM and WB.
- Load-use and coprocessor stalls, plus branch/jump flushes and PC source selection.
- A sticky, cause-encoded error register with software clear, a coprocessor timeout watchdog, and saturating stall/flush performance counters.

## Interface
Parameters:
- `ADDR_W`, 5, GPR address width
- `NUM_SRC`, 2, number of ID-stage source-register ports
- `COP_TIMEOUT`, 64, consecutive coprocessor-wait cycles before timeout error (>=2)
- `CNT_W`, 16, performance counter width

Ports:
- `clk` in 1 — single clock; all state on rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `enable_cpu` in 1 — global run enable
- `shift_error` in 1 — shifter fault pulse
- `src_addr` in NUM_SRC*ADDR_W — ID source addresses, port i at [i*ADDR_W +: ADDR_W]
- `src_read` in NUM_SRC — port i actually read by the ID instruction
- `ex_reg_write`, `ex_mem_rd` in 1 each — EX writes GPR / EX is a load
- `ex_wr_addr` in ADDR_W — EX destination
- `ex_branch_taken` in 1 — branch resolved taken in EX
- `mem_reg_write` in 1; `mem_wr_addr` in ADDR_W — MEM destination
- `wb_reg_write` in 1; `wb_wr_addr` in ADDR_W — WB destination
- `id_jump_flag` in 1 — jump decoded in ID
- `cop_working`, `cop_result_valid`, `cop_error` in 1 each — matrix coprocessor status
- `err_clear` in 1 — synchronous clear of error register
- `src_forward` out NUM_SRC*2 — port i select at [2i +: 2]
- `pc_src` out 2 — next-PC select
- `if_id_flush`, `id_ex_flush`, `if_id_stall` out 1 each
- `id_ex_cen`, `ex_mem_cen`, `mem_wb_cen` out 1 each
- `cpu_error` out 1 — OR of `error_cause`
- `error_cause` out 3 — sticky cause bits
- `stall_cnt`, `flush_cnt` out CNT_W each — saturating counters

## Operation
- Match for port i and stage S (S = EX, MEM, WB):
  - `S_reg_write`, `S_wr_addr != 0`, `S_wr_addr == src_addr[i]`, and `src_read[i]`.
- Forward select priority: EX (2'b01) > MEM (2'b10) > WB (2'b11), otherwise regfile (2'b00).
- Load-use on port i: EX match and `ex_mem_rd`. While load-use is active, port i select is forced to 2'b00.
- `load_use` = OR over ports. `cop_wait` = `cop_working & ~cop_result_valid`. `in_error` = `cpu_error`.
- `jump_ok` = `id_jump_flag & ~cop_wait`.
- Flushes:
  - `if_id_flush` = `ex_branch_taken | jump_ok`.
  - `id_ex_flush` = `if_id_flush | (load_use & ~ex_branch_taken)`.
- `if_id_stall` = `(load_use & ~ex_branch_taken) | ~enable_cpu | in_error | cop_wait`.
- All three stage enables = `enable_cpu & ~in_error & ~cop_wait`.
- `pc_src` encoding: NRM 2'b00, JPA 2'b01, BRA 2'b10. `ex_branch_taken` → BRA regardless of jump; else `jump_ok` → JPA; else NRM.
- Error register `error_cause` bits: [0] shift, [1] coprocessor, [2] timeout.
  - Bit [0] set by `shift_error`.
  - Bit [1] set by `cop_error & cop_result_valid`.
  - Bit [2] set when the watchdog reaches `COP_TIMEOUT`.
  - `err_clear` zeroes all bits. If a set and `err_clear` occur in the same cycle, the set wins for that bit.
- Watchdog: counter width `$clog2(COP_TIMEOUT+1)`.
  - Increments each cycle `cop_wait` is high; returns to 0 when `cop_wait` is low.
  - Saturates at `COP_TIMEOUT`.
  - Sets bit [2] on the edge where it goes from `COP_TIMEOUT-1` to `COP_TIMEOUT`.
- `stall_cnt` increments on cycles with `(load_use & ~ex_branch_taken) | cop_wait` while `enable_cpu` and not `in_error`.
- `flush_cnt` increments on cycles with `ex_branch_taken | jump_ok`.
- Both counters saturate at all-ones. Neither is cleared by `err_clear`.

## Timing
- Forward selects, flushes, stalls, enables and `pc_src` are combinational from current inputs and registered state; they have zero latency.
- Error bits appear one cycle after the causing event, and from then on force stall and disable the stage enables.
- Counters update on the edge ending the counted cycle.
- While `rst_n` is low:
  - `error_cause`, watchdog, `stall_cnt`, `flush_cnt` are 0.
  - `if_id_flush` = `id_ex_flush` = 1, forced combinationally.
  - All enables are 0, `if_id_stall` is 1.
  - `pc_src` is NRM.
- Reset deassertion mid-wait restarts the watchdog from 0.

## Structure
- Package `hazard_pkg` holds:
  - forward codes `FWD_RF/EX/MEM/WB`
  - `PCS_NRM/JPA/BRA`
  - error bit indices `ERR_SHIFT/COP/TIMEOUT`
- Sub-module `hazard_src_match`: one port's three stage compares, forward select and load-use flag. The top level instantiates it `NUM_SRC` times in a generate loop.

## Test plan
- Forward priority: port 0 = r3, EX/MEM/WB all write r3 → select 01. Drop EX → 10. Drop MEM → 11. Destination r0 everywhere → 00.
- Load-use: EX load to r5, port 1 reads r5 → `if_id_stall`=1, `id_ex_flush`=1, port 1 select 00, `stall_cnt`+1. Same cycle with `ex_branch_taken` → stall 0, `pc_src`=10.
- Jump during coprocessor wait: `id_jump_flag` with `cop_wait`=1 → no flush, `pc_src`=00, enables 0. Wait clears next cycle → `pc_src`=01, both flushes 1, `flush_cnt`+1.
- Watchdog: `COP_TIMEOUT`=4, `cop_wait` held high → `error_cause`=3'b100 and `cpu_error`=1 after the 4th edge, enables held 0. Wait held for 3 cycles then low → no error.
- Error clear: `shift_error` pulse → cause 001 next cycle. `err_clear` together with `cop_error & cop_result_valid` → cause 010. Lone `err_clear` → 000, pipeline resumes.
- Async reset mid-operation: counters nonzero and cause 101, drop `rst_n` between clock edges → all state 0 immediately, flushes 1; `stall_cnt` saturation checked at `CNT_W`=4 (stays 15).
